// File: rtl/cpu_hs_pkg.sv
// rtl/cpu_hs_pkg.sv - shared defaults and FSM encoding for the handshake sender
package cpu_hs_pkg;

  localparam int DEF_DATA_W  = 2;
  localparam int DEF_DEPTH   = 4;
  localparam int DEF_TIMEOUT = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_REL  = 2'b10
  } hs_state_t;

endpackage

// File: rtl/hs_fifo.sv
// rtl/hs_fifo.sv - synchronous transmit queue with head-of-queue peek
module hs_fifo
  import cpu_hs_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk2,
  input  logic              rst2,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       level
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       cnt;
  logic              do_push;
  logic              do_pop;

  assign do_push = push && (cnt != (AW+1)'(DEPTH));
  assign do_pop  = pop && (cnt != '0);

  // Pointers are exactly AW bits wide, so DEPTH being a power of two makes them wrap for free.
  always_ff @(posedge clk2 or negedge rst2) begin
    if (!rst2) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk2) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign level = cnt;
  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);

endmodule

// File: rtl/cpu_hs_sender.sv
// rtl/cpu_hs_sender.sv - queued four-phase request/ack sender with sticky error flags
module cpu_hs_sender
  import cpu_hs_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int TIMEOUT = DEF_TIMEOUT,
  localparam int LW     = $clog2(DEPTH) + 1
) (
  input  logic              clk2,
  input  logic              rst2,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              ack,
  input  logic              err_clr,
  output logic [DATA_W-1:0] dado,
  output logic              send,
  output logic              full,
  output logic              empty,
  output logic [LW-1:0]     level,
  output logic              ovf_err,
  output logic              tmo_err
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  hs_state_t         state;
  logic [CW-1:0]     tcnt;
  logic [CW:0]       tcnt_inc;
  logic              pop;
  logic              tmo_fire;
  logic [DATA_W-1:0] head;

  hs_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk2      (clk2),
    .rst2      (rst2),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  assign pop      = (state == ST_REQ) && ack;
  assign tcnt_inc = {1'b0, tcnt} + 1'b1;
  assign tmo_fire = (TIMEOUT != 0) && (state == ST_REQ) && !ack &&
                    (tcnt_inc == (CW+1)'(TIMEOUT));

  always_ff @(posedge clk2 or negedge rst2) begin
    if (!rst2) begin
      state   <= ST_IDLE;
      send    <= 1'b0;
      dado    <= '0;
      tcnt    <= '0;
      ovf_err <= 1'b0;
      tmo_err <= 1'b0;
    end else begin
      // A fresh error event wins over a clear in the same cycle.
      if (wr_en && full)  ovf_err <= 1'b1;
      else if (err_clr)   ovf_err <= 1'b0;
      if (tmo_fire)       tmo_err <= 1'b1;
      else if (err_clr)   tmo_err <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (!empty) begin
            state <= ST_REQ;
            send  <= 1'b1;
            dado  <= head;
            tcnt  <= '0;
          end
        end
        ST_REQ: begin
          if (ack) begin
            state <= ST_REL;
            send  <= 1'b0;
            dado  <= '0;
          end else if (tmo_fire) begin
            // Word stays queued; IDLE will re-issue it.
            state <= ST_IDLE;
            send  <= 1'b0;
            dado  <= '0;
          end else begin
            tcnt <= tcnt_inc[CW-1:0];
          end
        end
        ST_REL: begin
          if (!ack) begin
            if (!empty) begin
              state <= ST_REQ;
              send  <= 1'b1;
              dado  <= head;
              tcnt  <= '0;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          send  <= 1'b0;
          dado  <= '0;
        end
      endcase
    end
  end

endmodule
